// File: rtl/ac97_pcm_link.sv
// AC'97 AC-link controller: PCM playback FIFO, slot 1/2 register commands, status read-back decode.
// Optional AC97_SLOTREQ_EN: gate PCM pops on the codec's slot-3 request bit (variable-rate audio).
module ac97_pcm_link #(
  parameter int unsigned PCM_WIDTH  = 16,
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          ac97_bitclk,
  input  logic                          ac97_rst,
  input  logic                          ac97_sdata_in,
  output logic                          ac97_sdata_out,
  output logic                          ac97_sync,
  output logic                          ac97_reset_b,
  input  logic [CHANNELS*PCM_WIDTH-1:0] pcm_data,
  input  logic                          pcm_valid,
  output logic                          pcm_ready,
  input  logic [6:0]                    cmd_addr,
  input  logic [15:0]                   cmd_data,
  input  logic                          cmd_read,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  output logic [6:0]                    rsp_addr,
  output logic [15:0]                   rsp_data,
  output logic                          rsp_valid,
  output logic                          codec_ready,
  output logic                          underrun,
  input  logic                          underrun_clr,
  output logic                          frame_strobe
);

  localparam int unsigned DW = CHANNELS * PCM_WIDTH;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {CMD_IDLE, CMD_PEND} cmd_state_t;

  cmd_state_t     cmd_state, cmd_next;
  logic [7:0]     bit_cnt, next_cnt;
  logic           load, rx_latch, cmd_pend, push, pop, pop_ok, ever_popped;
  logic           cmd_rd_q;
  logic [6:0]     cmd_addr_q;
  logic [15:0]    cmd_data_q;
  logic [DW-1:0]  mem [FIFO_DEPTH];
  logic [DW-1:0]  rd_word;
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count;
  logic [15:0]    tag;
  logic [19:0]    slot1, slot2, slot3, slot4;
  logic [255:0]   out_shift;
  logic [254:0]   in_shift;

  assign next_cnt = bit_cnt + 8'd1;
  assign load     = (bit_cnt == 8'hFF);
  assign rx_latch = (bit_cnt == 8'h00);

  always_ff @(posedge ac97_bitclk or posedge ac97_rst) begin
    if (ac97_rst) begin
      bit_cnt      <= 8'hFF;
      ac97_sync    <= 1'b0;
      frame_strobe <= 1'b0;
      ac97_reset_b <= 1'b0;
    end else begin
      bit_cnt      <= next_cnt;
      ac97_sync    <= (next_cnt == 8'hFF) || (next_cnt < 8'd15);
      frame_strobe <= load;
      ac97_reset_b <= 1'b1;
    end
  end

  assign cmd_pend = (cmd_state == CMD_PEND);

  always_comb begin
    cmd_next  = cmd_state;
    cmd_ready = 1'b0;
    case (cmd_state)
      CMD_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) cmd_next = CMD_PEND;
      end
      CMD_PEND: if (load) cmd_next = CMD_IDLE;
      default:  cmd_next = CMD_IDLE;
    endcase
  end

  always_ff @(posedge ac97_bitclk or posedge ac97_rst) begin
    if (ac97_rst) begin
      cmd_state  <= CMD_IDLE;
      cmd_rd_q   <= 1'b0;
      cmd_addr_q <= '0;
      cmd_data_q <= '0;
    end else begin
      cmd_state <= cmd_next;
      if (cmd_valid && cmd_ready) begin
        cmd_rd_q   <= cmd_read;
        cmd_addr_q <= cmd_addr;
        cmd_data_q <= cmd_data;
      end
    end
  end

`ifdef AC97_SLOTREQ_EN
  logic slot_req;
  assign pop_ok = slot_req;
`else
  assign pop_ok = 1'b1;
`endif

  // No bypass: an empty FIFO at the load edge sends an empty frame even if a push lands on that edge.
  assign pcm_ready = (count != FULL);
  assign push      = pcm_valid && pcm_ready;
  assign pop       = load && pop_ok && (count != '0);
  assign rd_word   = mem[rd_ptr];

  always_ff @(posedge ac97_bitclk) begin
    if (push) mem[wr_ptr] <= pcm_data;
  end

  always_ff @(posedge ac97_bitclk or posedge ac97_rst) begin
    if (ac97_rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      ever_popped <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr      <= rd_ptr + 1'b1;
        ever_popped <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (load && pop_ok && (count == '0) && ever_popped) underrun <= 1'b1;
      else if (underrun_clr)                              underrun <= 1'b0;
    end
  end

  always_comb begin
    tag     = '0;
    slot1   = '0;
    slot2   = '0;
    slot3   = '0;
    slot4   = '0;
    tag[15] = 1'b1;
    tag[14] = cmd_pend;
    tag[13] = cmd_pend && !cmd_rd_q;
    tag[12] = pop;
    tag[11] = pop && (CHANNELS == 2);
    if (cmd_pend) begin
      slot1 = {cmd_rd_q, cmd_addr_q, 12'h000};
      if (!cmd_rd_q) slot2 = {cmd_data_q, 4'h0};
    end
    if (pop) begin
      slot3 = 20'(rd_word[PCM_WIDTH-1:0]) << (20 - PCM_WIDTH);
      if (CHANNELS == 2) slot4 = 20'(rd_word[DW-1 -: PCM_WIDTH]) << (20 - PCM_WIDTH);
    end
  end

  always_ff @(posedge ac97_bitclk or posedge ac97_rst) begin
    if (ac97_rst)  out_shift <= '0;
    else if (load) out_shift <= {tag, slot1, slot2, slot3, slot4, 160'h0};
    else           out_shift <= {out_shift[254:0], 1'b0};
  end

  assign ac97_sdata_out = out_shift[255];

  // At the bit_cnt==0 edge the full frame is {in_shift, sdata_in}; frame bit j sits at in_shift[j-1].
  always_ff @(posedge ac97_bitclk or posedge ac97_rst) begin
    if (ac97_rst) begin
      in_shift    <= '0;
      codec_ready <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_addr    <= '0;
      rsp_data    <= '0;
`ifdef AC97_SLOTREQ_EN
      slot_req    <= 1'b0;
`endif
    end else begin
      in_shift  <= {in_shift[253:0], ac97_sdata_in};
      rsp_valid <= 1'b0;
      if (rx_latch) begin
        codec_ready <= in_shift[254];
        if (in_shift[253] && in_shift[252]) begin
          rsp_valid <= 1'b1;
          rsp_addr  <= in_shift[237:231];
          rsp_data  <= in_shift[218:203];
        end
`ifdef AC97_SLOTREQ_EN
        slot_req <= !in_shift[230];
`endif
      end
    end
  end

endmodule

// File: tb/tb_ac97_pcm_link.sv
// Scoreboard bench for ac97_pcm_link: expected tx frames and responses are queued at stimulus time.
module tb_ac97_pcm_link;
  localparam int PW = 16;
  localparam int CH = 2;
  localparam int FD = 8;
  localparam logic [255:0] EMPTY = {16'h8000, 240'h0};

  logic clk = 1'b0, rst = 1'b1, sdata_in = 1'b0;
  logic sdata_out, sync, reset_b;
  logic [CH*PW-1:0] pcm_data = '0;
  logic pcm_valid = 1'b0, pcm_ready;
  logic [6:0] cmd_addr = '0;
  logic [15:0] cmd_data = '0;
  logic cmd_read = 1'b0, cmd_valid = 1'b0, cmd_ready;
  logic [6:0] rsp_addr;
  logic [15:0] rsp_data;
  logic rsp_valid, codec_ready, underrun, frame_strobe;
  logic underrun_clr = 1'b0;

  int errors = 0, checks = 0, tx_seen = 0;
  logic [7:0]   pos;
  logic [255:0] tx_q[$], rx_q[$];
  logic [22:0]  rsp_q[$];
  logic [255:0] rx_cur = '0, txbits = '0;

  ac97_pcm_link #(.PCM_WIDTH(PW), .CHANNELS(CH), .FIFO_DEPTH(FD)) dut (
    .ac97_bitclk(clk), .ac97_rst(rst), .ac97_sdata_in(sdata_in), .ac97_sdata_out(sdata_out),
    .ac97_sync(sync), .ac97_reset_b(reset_b), .pcm_data(pcm_data), .pcm_valid(pcm_valid),
    .pcm_ready(pcm_ready), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_read(cmd_read),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
    .rsp_valid(rsp_valid), .codec_ready(codec_ready), .underrun(underrun),
    .underrun_clr(underrun_clr), .frame_strobe(frame_strobe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] frm(input logic [15:0] t, input logic [19:0] a, b, c, d);
    return {t, a, b, c, d, 160'h0};
  endfunction

  task automatic wait_pos(input logic [7:0] p);
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (pos == p) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_pos: bit position %0d never reached", p);
  endtask

  // Bit position of the current cycle, counted from reset release.
  always @(posedge clk or posedge rst)
    if (rst) pos <= 8'd255;
    else     pos <= pos + 8'd1;

  // Codec model: frame bit k is presented during the cycle at position k+1.
  always @(negedge clk) begin
    if (pos == 8'd1) rx_cur = (rx_q.size() != 0) ? rx_q.pop_front() : '0;
    sdata_in = rx_cur[8'd255 - (pos - 8'd1)];
  end

  always @(negedge clk) begin
    if (!rst) begin
      txbits = {txbits[254:0], sdata_out};
      if (pos == 8'd255 && txbits !== EMPTY) begin
        if (tx_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected: got %0h, want empty frame", txbits);
        end else begin
          chk("tx_frame", txbits, tx_q.pop_front());
          tx_seen++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (rsp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got %0h, want no response", {rsp_addr, rsp_data});
      end else begin
        chk("rsp", {rsp_addr, rsp_data}, rsp_q.pop_front());
        chk("codec_ready_at_rsp", codec_ready, 1'b1);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int sync_hi, rises, bad_rises, strobes, bad_strobes, seen;
    logic prev;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {sdata_out, sync, reset_b, pcm_ready, cmd_ready, rsp_valid,
                          codec_ready, underrun, frame_strobe}, 9'b0_0_0_1_1_0_0_0_0);
    chk("reset_rsp", {rsp_addr, rsp_data}, 23'h0);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("reset_b_release", reset_b, 1'b1);

    sync_hi = 0; rises = 0; bad_rises = 0; strobes = 0; bad_strobes = 0; prev = 1'b1;
    for (int i = 0; i < 512; i++) begin
      if (i > 0) @(negedge clk);
      sync_hi += int'(sync);
      if (sync && !prev) begin
        if (pos == 8'd255) rises++;
        else bad_rises++;
      end
      strobes += int'(frame_strobe);
      if (frame_strobe != (pos == 8'd0)) bad_strobes++;
      prev = sync;
    end
    chk("sync_width", sync_hi, 32);
    chk("sync_rise_pos", {rises, bad_rises}, {32'd2, 32'd0});
    chk("strobe_count", {strobes, bad_strobes}, {32'd2, 32'd0});
    chk("codec_ready_idle", codec_ready, 1'b0);

    // PCM frame, then underrun and its clear
    wait_pos(100);
    pcm_data = {16'h5678, 16'h1234};
    pcm_valid = 1'b1;
    tx_q.push_back(frm(16'h9800, 20'h0, 20'h0, 20'h12340, 20'h56780));
    @(negedge clk);
    pcm_valid = 1'b0;
    chk("underrun_before_pop", underrun, 1'b0);
    wait_pos(10);
    chk("underrun_after_pop", underrun, 1'b0);
    wait_pos(10);
    chk("underrun_set", underrun, 1'b1);
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    chk("underrun_clr", underrun, 1'b0);
    wait_pos(254);
    underrun_clr = 1'b1;
    @(negedge clk);
    chk("underrun_clr_pre_load", underrun, 1'b0);
    @(negedge clk);
    chk("underrun_set_wins", underrun, 1'b1);
    underrun_clr = 1'b0;

    // Write command, then a read accepted on the load edge
    wait_pos(100);
    {cmd_addr, cmd_data, cmd_read, cmd_valid} = {7'h02, 16'h0808, 1'b0, 1'b1};
    tx_q.push_back(frm(16'hE000, 20'h02000, 20'h08080, 20'h0, 20'h0));
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("cmd_ready_after_accept", cmd_ready, 1'b0);
    wait_pos(255);
    chk("cmd_ready_before_load", cmd_ready, 1'b0);
    @(negedge clk);
    chk("cmd_ready_after_load", cmd_ready, 1'b1);
    wait_pos(255);
    {cmd_addr, cmd_data, cmd_read, cmd_valid} = {7'h26, 16'hFFFF, 1'b1, 1'b1};
    tx_q.push_back(frm(16'hC000, 20'hA6000, 20'h0, 20'h0, 20'h0));
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("cmd_on_load_accepted", cmd_ready, 1'b0);
    wait_pos(255);
    chk("cmd_on_load_waits", cmd_ready, 1'b0);
    @(negedge clk);
    chk("cmd_on_load_sent", cmd_ready, 1'b1);

    // Command and PCM in the same frame
    wait_pos(100);
    {cmd_addr, cmd_data, cmd_read, cmd_valid} = {7'h7F, 16'hABCD, 1'b0, 1'b1};
    pcm_data = {16'hCAFE, 16'hBEEF};
    pcm_valid = 1'b1;
    tx_q.push_back(frm(16'hF800, 20'h7F000, 20'hABCD0, 20'hBEEF0, 20'hCAFE0));
    @(negedge clk);
    cmd_valid = 1'b0;
    pcm_valid = 1'b0;

    // Codec status frames: one with a response, one without
    wait_pos(100);
    rx_q.push_back({16'hE000, 20'h26000, 20'h000F0, 200'h0});
    rsp_q.push_back({7'h26, 16'h000F});
    rx_q.push_back({16'hC000, 20'h26000, 20'h000F0, 200'h0});
    wait_pos(5);
    wait_pos(5);
    wait_pos(5);
    chk("codec_ready_no_rsp", codec_ready, 1'b1);
    wait_pos(5);
    chk("codec_ready_cleared", codec_ready, 1'b0);
    chk("rsp_queue_drained", rsp_q.size(), 0);

    // Fill the FIFO: 8 accepted, the 9th held until the next load
    wait_pos(10);
    for (int i = 0; i < 9; i++) begin
      pcm_data = {16'hB000 | 16'(i), 16'hA000 | 16'(i)};
      pcm_valid = 1'b1;
      tx_q.push_back(frm(16'h9800, 20'h0, 20'h0, {16'hA000 | 16'(i), 4'h0}, {16'hB000 | 16'(i), 4'h0}));
      if (i < 8) @(negedge clk);
    end
    chk("fifo_full", pcm_ready, 1'b0);
    wait_pos(255);
    chk("fifo_full_held", pcm_ready, 1'b0);
    @(negedge clk);
    chk("ready_after_pop", pcm_ready, 1'b1);
    @(negedge clk);
    pcm_valid = 1'b0;
    chk("refull_after_ninth", pcm_ready, 1'b0);
    repeat (10) wait_pos(128);

`ifdef AC97_SLOTREQ_EN
    wait_pos(100);
    rx_q.push_back({16'h8000, 20'h00800, 220'h0});
    wait_pos(5);
    wait_pos(5);
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    wait_pos(5);
    chk("slotreq_no_underrun", underrun, 1'b0);
    wait_pos(100);
    rx_q.push_back({16'h8000, 20'h00800, 220'h0});
    wait_pos(10);
    wait_pos(10);
    pcm_data = {16'h0002, 16'h0001};
    pcm_valid = 1'b1;
    tx_q.push_back(frm(16'h9800, 20'h0, 20'h0, 20'h00010, 20'h00020));
    seen = tx_seen;
    @(negedge clk);
    pcm_valid = 1'b0;
    wait_pos(5);
    wait_pos(5);
    chk("slotreq_deferred", tx_seen, seen);
    wait_pos(5);
    chk("slotreq_popped", tx_seen, seen + 1);
`endif

    chk("tx_queue_drained", tx_q.size(), 0);
    chk("rx_queue_drained", rx_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
